// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the four-digit display limits.
package bcd_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX    = 9999;
    localparam int BCD_BITS   = 4 * BCD_DIGITS;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: add 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_adj3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Digits and ovf update only on completion so the display never sees partial results.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int MAXVAL = BCD_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       Dig0,
    output logic [3:0]       Dig1,
    output logic [3:0]       Dig2,
    output logic [3:0]       Dig3
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT_VAL  = WIDTH'(MAXVAL);

    logic [1:0]                r_rst_sync;
    logic                      w_rst_n;

    state_t                    r_state;
    logic [WIDTH-1:0]          r_bin;
    logic [BCD_BITS-1:0]       r_scratch;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_ovf_int;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_ovf;
    logic [BCD_BITS-1:0]       r_dig;

    logic                      w_over;
    logic [BCD_BITS-1:0]       w_adj;
    logic [BCD_BITS+WIDTH-1:0] w_sh;

    // Reset asserts immediately but releases on a clock edge, so no flop
    // sees reset removal close to its active edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_over = (32'(bin) > 32'(MAXVAL));

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj3 (
            .i_nib (r_scratch[4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
        );
    end

    assign w_sh = {w_adj, r_bin} << 1;

    // NOTE: every register here uses <= so each update sees the pre-edge
    // values of its neighbours, whatever the statement order.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_dig     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin     <= w_over ? SAT_VAL : bin;
                        r_ovf_int <= w_over;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_sh[BCD_BITS+WIDTH-1:WIDTH];
                    r_bin     <= w_sh[WIDTH-1:0];
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_dig   <= w_sh[BCD_BITS+WIDTH-1:WIDTH];
                        r_ovf   <= r_ovf_int;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign Dig0 = r_dig[3:0];
    assign Dig1 = r_dig[7:4];
    assign Dig2 = r_dig[11:8];
    assign Dig3 = r_dig[15:12];

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter, upstream of the four-digit seven-segment display block. Takes an unsigned binary value with a start strobe and runs shift-and-add-3 (double dabble), one bit per clock. Drives the display's four digit inputs `Dig0`..`Dig3`, and holds them stable between conversions so the display never shows partial results.

## Interface

**Parameters**
- `WIDTH`, default 14: binary input width. Legal range is 4..14.
- `MAXVAL`, default 9999: saturation limit. This is the largest value four BCD digits can show.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset. Asserts the instant it goes low; deasserts synchronously to `clk`.
- `start` in 1: conversion request. Sampled only in IDLE.
- `bin` in WIDTH: value to convert. Captured on the edge that accepts `start`.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when new digits are valid.
- `ovf` out 1: high when the last captured `bin` exceeded `MAXVAL`. Held until the next completion.
- `Dig0` out 4: BCD ones digit.
- `Dig1` out 4: BCD tens digit.
- `Dig2` out 4: BCD hundreds digit.
- `Dig3` out 4: BCD thousands digit.

## Operation

**States**
- IDLE → LOAD-then-SHIFT on `start`=1 in IDLE.
- SHIFT → IDLE when the iteration counter reaches WIDTH-1.
- There is no separate LOAD state; loading happens on the accepting edge.

**Accepting edge (IDLE, `start`=1)**
- Capture `min(bin, MAXVAL)` into the binary shift register.
- Set the internal ovf flag to (`bin` > `MAXVAL`).
- Clear the 16-bit BCD scratch register and set the counter to 0.

**Each SHIFT edge**
- For each scratch nibble ≥ 5, add 3 to it. The add never carries across nibbles.
- Then shift {scratch, binary} left by 1.
- Increment the counter.

**Final SHIFT edge (counter = WIDTH-1)**
- Write the post-shift scratch nibbles to `Dig3..Dig0`, most significant first.
- Copy the internal ovf flag to `ovf`.
- Set `done`=1 and return to IDLE.

**Other rules**
- `Dig0..Dig3` and `ovf` change only on completion. They hold their prior values throughout a conversion.
- `start` in SHIFT is ignored. It is not queued.
- `start` in the `done` cycle is legal and is accepted, because the block is in IDLE.
- `bin` is don't-care except on the accepting edge.
- Every digit output is always in 0..9.
- Reset values: state IDLE, `busy`=0, `done`=0, `ovf`=0, `Dig0..Dig3`=0, all scratch registers and the counter 0.
- Reset during SHIFT aborts the conversion immediately. No `done` is produced and the digits read 0.

## Timing

- Take the start-accepting edge as edge 0. Then:
  - `busy`=1 after edges 0..WIDTH-1.
  - Iterations occur on edges 1..WIDTH.
  - Digits are valid and `done`=1 after edge WIDTH (edge 14 by default).
  - `busy`=0 in the `done` cycle.
- Start-to-done latency is WIDTH+1 clock edges (15 by default).
- Maximum throughput is one conversion per WIDTH+1 cycles, with `start` held high or re-asserted in the `done` cycle.
- `busy`, `done`, `ovf` and the digits are all registered outputs. There are no combinational paths from inputs to outputs.

## Structure

- Shared package `bcd_pkg` holds:
  - the state encoding (`ST_IDLE`, `ST_SHIFT`);
  - `BCD_DIGITS`=4;
  - `BCD_MAX`=9999.
- Counter width is derived as clog2(WIDTH).
- One natural sub-module, `bcd_adj3`: a combinational 4-bit nibble adjust (in ≥ 5 ? in+3 : in). Instantiate it four times on the scratch register.

## Test plan

- `bin`=1234, `start` pulsed → after 15 edges `Dig3..Dig0`=1,2,3,4, `ovf`=0, `done` high exactly 1 cycle, `busy` high 14 cycles.
- `bin`=0, then `bin`=9999 back-to-back (second `start` in the `done` cycle) → digits 0,0,0,0 then 9,9,9,9. Second `done` arrives 15 edges after the first.
- `bin`=12000 (above `MAXVAL`) → digits 9,9,9,9 and `ovf`=1. Next conversion of 42 → 0,0,4,2 and `ovf`=0.
- Start 1234 and let it complete, then start 5678 and pulse `start` again mid-SHIFT with `bin`=1111 → extra `start` ignored. Digits hold 1,2,3,4 until the completion edge, then show 5,6,7,8 with exactly one `done`.
- Assert `reset` low asynchronously at iteration 7 of converting 8765 → outputs go to 0 immediately with no clock edge, no `done` follows, IDLE after release. A following conversion of 305 → 0,3,0,5.
- Random sweep of 0..16383 → every result matches `min(bin, 9999)` in decimal, every digit ≤ 9, `ovf` is correct.
